// File: rtl/bnn_maxpool2d.sv
// bnn_maxpool2d: binary 2x2 stride-2 max-pool stage for the BNN pipeline.
// Consumes flattened per-channel binary maps under a level handshake and
// writes one pooled output row of one channel per clock while running.
// Optional build macro: BNN_POOL_MAJORITY_EN selects majority-of-4 pooling
// instead of OR (max) pooling. The timing and the handshake are the same in
// both builds.
module bnn_maxpool2d #(
  parameter  int unsigned C            = 8,
  parameter  int unsigned IMG_IN_SIZE  = 28,
  localparam int unsigned IMG_OUT_SIZE = IMG_IN_SIZE / 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   data_in_ready,
  input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]     img_in  [0:C-1],
  output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]   img_out [0:C-1],
  output logic                                   data_out_ready,
  output logic                                   busy
);

  localparam int unsigned IN_BITS   = IMG_IN_SIZE * IMG_IN_SIZE;
  localparam int unsigned OUT_BITS  = IMG_OUT_SIZE * IMG_OUT_SIZE;
  localparam int unsigned CH_W      = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned ROW_W     = (IMG_OUT_SIZE > 1) ? $clog2(IMG_OUT_SIZE) : 1;
  localparam int unsigned IN_IDX_W  = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam int unsigned OUT_IDX_W = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic                      dor_d;
  logic                      busy_d;
  logic                      wr_c;
  logic                      clr_c;
  logic [IMG_OUT_SIZE-1:0]   row_bits_c;
  logic [OUT_IDX_W-1:0]      out_base_c;

  // Pool the two input rows that feed output row row_q of channel ch_q.
  always_comb begin
    logic [IN_IDX_W-1:0] i00, i01, i10, i11;
    logic [3:0]          win;
    logic [2:0]          pc;
    row_bits_c = '0;
    i00 = '0;
    i01 = '0;
    i10 = '0;
    i11 = '0;
    win = '0;
    pc  = '0;
    for (int unsigned c = 0; c < IMG_OUT_SIZE; c++) begin
      i00 = IN_IDX_W'((2 * 32'(row_q)) * IMG_IN_SIZE + 2 * c);
      i01 = IN_IDX_W'((2 * 32'(row_q)) * IMG_IN_SIZE + 2 * c + 1);
      i10 = IN_IDX_W'((2 * 32'(row_q) + 1) * IMG_IN_SIZE + 2 * c);
      i11 = IN_IDX_W'((2 * 32'(row_q) + 1) * IMG_IN_SIZE + 2 * c + 1);
      win = {img_in[ch_q][i11], img_in[ch_q][i10], img_in[ch_q][i01], img_in[ch_q][i00]};
      pc  = 3'(win[0]) + 3'(win[1]) + 3'(win[2]) + 3'(win[3]);
`ifdef BNN_POOL_MAJORITY_EN
      row_bits_c[c] = (pc >= 3'd2);
`else
      row_bits_c[c] = (pc != 3'd0);
`endif
    end
    out_base_c = OUT_IDX_W'(32'(row_q) * IMG_OUT_SIZE);
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    row_d   = row_q;
    dor_d   = 1'b0;
    busy_d  = 1'b0;
    wr_c    = 1'b0;
    clr_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_in_ready) begin
          state_d = RUN;
          ch_d    = '0;
          row_d   = '0;
          busy_d  = 1'b1;
        end else begin
          clr_c = 1'b1;
        end
      end
      RUN: begin
        if (!data_in_ready) begin
          // Abort: drop the partial frame, never flag it valid.
          state_d = IDLE;
          ch_d    = '0;
          row_d   = '0;
          clr_c   = 1'b1;
        end else begin
          wr_c = 1'b1;
          if (ch_q == CH_W'(C - 1) && row_q == ROW_W'(IMG_OUT_SIZE - 1)) begin
            state_d = DONE;
            ch_d    = '0;
            row_d   = '0;
            dor_d   = 1'b1;
          end else begin
            busy_d = 1'b1;
            if (row_q == ROW_W'(IMG_OUT_SIZE - 1)) begin
              row_d = '0;
              ch_d  = CH_W'(ch_q + 1'b1);
            end else begin
              row_d = ROW_W'(row_q + 1'b1);
            end
          end
        end
      end
      DONE: begin
        if (data_in_ready) begin
          dor_d = 1'b1;
        end else begin
          state_d = IDLE;
          clr_c   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = '0;
        row_d   = '0;
        clr_c   = 1'b1;
      end
    endcase
  end

  // State, counters and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      row_q          <= '0;
      data_out_ready <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      row_q          <= row_d;
      data_out_ready <= dor_d;
      busy           <= busy_d;
    end
  end

  // Output maps: clear when idle/aborting, else write one pooled row per edge.
  always_ff @(posedge clk) begin
    if (rst || clr_c) begin
      for (int unsigned ch = 0; ch < C; ch++) begin
        img_out[ch] <= '0;
      end
    end else if (wr_c) begin
      img_out[ch_q][out_base_c +: IMG_OUT_SIZE] <= row_bits_c;
    end
  end

endmodule

// File: tb/tb_bnn_maxpool2d.sv
// tb_bnn_maxpool2d: directed bench for bnn_maxpool2d with a frame-level
// reference model (default 8x28 instance plus an odd 2x5 instance).
module tb_bnn_maxpool2d;

  localparam int C_A = 8, IS_A = 28, OS_A = 14, N_A = C_A * OS_A;
  localparam int C_B = 2, IS_B = 5,  OS_B = 2,  N_B = C_B * OS_B;

  logic clk;
  logic rst;
  logic din_a, din_b;
  logic dor_a, dor_b, busy_a, busy_b;
  logic [IS_A*IS_A-1:0] img_a [0:C_A-1];
  logic [OS_A*OS_A-1:0] out_a [0:C_A-1];
  logic [IS_B*IS_B-1:0] img_b [0:C_B-1];
  logic [OS_B*OS_B-1:0] out_b [0:C_B-1];

  int tests  = 0;
  int errors = 0;
  int k_a    = 0;
  int k_b    = 0;

  bnn_maxpool2d #(.C(C_A), .IMG_IN_SIZE(IS_A)) dut_a (
    .clk(clk), .rst(rst), .data_in_ready(din_a), .img_in(img_a),
    .img_out(out_a), .data_out_ready(dor_a), .busy(busy_a)
  );

  bnn_maxpool2d #(.C(C_B), .IMG_IN_SIZE(IS_B)) dut_b (
    .clk(clk), .rst(rst), .data_in_ready(din_b), .img_in(img_b),
    .img_out(out_b), .data_out_ready(dor_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [783:0] got, input logic [783:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One 2x2 window of map m (side is), output pixel (r,c).
  function automatic logic pool_win(input logic [783:0] m, input int is, input int r, input int c);
    int cnt;
    cnt = int'(m[(2*r)*is + 2*c]) + int'(m[(2*r)*is + 2*c + 1])
        + int'(m[(2*r+1)*is + 2*c]) + int'(m[(2*r+1)*is + 2*c + 1]);
`ifdef BNN_POOL_MAJORITY_EN
    return cnt >= 2;
`else
    return cnt >= 1;
`endif
  endfunction

  // Expected output map of one channel after k consecutive high edges:
  // edge 0 starts the frame, each later edge completes one (ch,row) in order.
  function automatic logic [783:0] exp_map(input logic [783:0] m, input int is, input int ch, input int k);
    logic [783:0] e;
    int os;
    os = is / 2;
    e  = '0;
    for (int r = 0; r < os; r++)
      for (int c = 0; c < os; c++)
        if (ch * os + r < k - 1) e[r*os + c] = pool_win(m, is, r, c);
    return e;
  endfunction

  // Reference model update on each edge, then compare all outputs.
  always @(posedge clk) begin
    if (rst) begin
      k_a = 0;
      k_b = 0;
    end else begin
      if (!din_a) k_a = 0; else if (k_a <= N_A) k_a++;
      if (!din_b) k_b = 0; else if (k_b <= N_B) k_b++;
    end
    #1;
    chk("dor_a",  784'(dor_a),  784'(k_a >= N_A + 1));
    chk("busy_a", 784'(busy_a), 784'(k_a >= 1 && k_a <= N_A));
    for (int ch = 0; ch < C_A; ch++)
      chk($sformatf("img_a[%0d]", ch), 784'(out_a[ch]), exp_map(784'(img_a[ch]), IS_A, ch, k_a));
    chk("dor_b",  784'(dor_b),  784'(k_b >= N_B + 1));
    chk("busy_b", 784'(busy_b), 784'(k_b >= 1 && k_b <= N_B));
    for (int ch = 0; ch < C_B; ch++)
      chk($sformatf("img_b[%0d]", ch), 784'(out_b[ch]), exp_map(784'(img_b[ch]), IS_B, ch, k_b));
  end

  // Count edges from the first sampled request until data_out_ready shows.
  task automatic wait_dor(input int which, output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 400) begin
      @(posedge clk);
      #2;
      n++;
      if ((which == 0) ? dor_a : dor_b) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) begin
      tests++;
      errors++;
      $display("FAIL wait_dor%0d timeout got=none exp=data_out_ready", which);
    end
  endtask

  task automatic frame(input int which, output int lat);
    @(negedge clk);
    if (which == 0) din_a = 1'b1; else din_b = 1'b1;
    wait_dor(which, lat);
  endtask

  task automatic drop(input int which);
    @(negedge clk);
    if (which == 0) din_a = 1'b0; else din_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [OS_A*OS_A-1:0] w;
    rst   = 1'b1;
    din_a = 1'b0;
    din_b = 1'b0;
    for (int c = 0; c < C_A; c++) img_a[c] = '0;
    for (int c = 0; c < C_B; c++) img_b[c] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_a3", 784'(out_a[3]), 784'(0));
    chk("reset_dor_a",  784'(dor_a),    784'(0));

    // All ones: 112-edge latency, every word all ones.
    for (int c = 0; c < C_A; c++) img_a[c] = '1;
    frame(0, lat);
    chk("lat_ones", 784'(lat), 784'(112));
    w = '1;
    for (int c = 0; c < C_A; c++) chk("ones_word", 784'(out_a[c]), 784'(w));
    // Hold after done for 20 cycles, then drop.
    repeat (20) @(negedge clk);
    chk("hold_dor",  784'(dor_a),  784'(1));
    chk("hold_busy", 784'(busy_a), 784'(0));
    din_a = 1'b0;
    @(negedge clk);
    chk("drop_dor",  784'(dor_a),    784'(0));
    chk("drop_img0", 784'(out_a[0]), 784'(0));

    // All zeros.
    for (int c = 0; c < C_A; c++) img_a[c] = '0;
    frame(0, lat);
    chk("lat_zeros", 784'(lat), 784'(112));
    chk("zeros_img5", 784'(out_a[5]), 784'(0));
    drop(0);

    // Single pixel (3,5,9) -> out bit 32 of channel 3 in the OR build.
    img_a[3][5*IS_A + 9] = 1'b1;
    frame(0, lat);
    w = '0;
`ifndef BNN_POOL_MAJORITY_EN
    w[32] = 1'b1;
`endif
    chk("single_px", 784'(out_a[3]), 784'(w));
    drop(0);
    img_a[3][4*IS_A + 8] = 1'b1;
    frame(0, lat);
    w = '0;
    w[32] = 1'b1;
    chk("two_px", 784'(out_a[3]), 784'(w));
    drop(0);

    // Abort at edge 30, then a full frame of random data.
    for (int c = 0; c < C_A; c++)
      for (int i = 0; i < IS_A*IS_A; i++) img_a[c][i] = 1'($urandom_range(0, 1));
    @(negedge clk);
    din_a = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    din_a = 1'b0;
    @(negedge clk);
    chk("abort_dor", 784'(dor_a), 784'(0));
    frame(0, lat);
    chk("lat_rearm", 784'(lat), 784'(112));
    drop(0);

    // Reset at edge 50 with the request held high; fresh frame afterwards.
    @(negedge clk);
    din_a = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_dor",  784'(dor_a),  784'(0));
    chk("rst_mid_busy", 784'(busy_a), 784'(0));
    chk("rst_mid_img",  784'(out_a[0]), 784'(0));
    wait_dor(0, lat);
    chk("lat_after_rst", 784'(lat), 784'(112));
    drop(0);

    // Odd size: last row and column never reach the output.
    for (int c = 0; c < C_B; c++)
      for (int i = 0; i < IS_B; i++) begin
        img_b[c][4*IS_B + i] = 1'b1;
        img_b[c][i*IS_B + 4] = 1'b1;
      end
    frame(1, lat);
    chk("lat_odd", 784'(lat), 784'(4));
    chk("odd_edge0", 784'(out_b[0]), 784'(0));
    chk("odd_edge1", 784'(out_b[1]), 784'(0));
    drop(1);
    img_b[1][0] = 1'b1;
    img_b[1][1] = 1'b1;
    img_b[1][5] = 1'b1;
    img_b[1][6] = 1'b1;
    img_b[0][3*IS_B + 3] = 1'b1;
    frame(1, lat);
    chk("odd_full_win", 784'(out_b[1]), 784'(4'b0001));
    drop(1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bnn_maxpool2d.md
Name: bnn_maxpool2d

Overview:
- Binary 2x2, stride-2 max-pool stage sitting directly downstream of the Conv2d convolution stage.
- Consumes the per-channel flattened binary feature maps and the data_ready level handshake that Conv2d produces.
- Emits half-resolution maps, one output row of one channel per cycle, to the next conv or dense stage.
- Same level-handshake style as the conv stage: the downstream stage starts on data_out_ready high.

Parameters:
C, 8, number of channels (equals upstream OC)
IMG_IN_SIZE, 28, input map side length (equals upstream IMG_OUT_SIZE)
IMG_OUT_SIZE, IMG_IN_SIZE/2 (floor), output map side length

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
data_in_ready  input  1  level; high = img_in valid and held stable until dropped
img_in  input  [IMG_IN_SIZE*IMG_IN_SIZE-1:0] x [0:C-1]  input maps, pixel (r,c) at bit r*IMG_IN_SIZE+c
img_out  output  [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] x [0:C-1]  pooled maps, pixel (r,c) at bit r*IMG_OUT_SIZE+c
data_out_ready  output  1  level; high = all of img_out valid
busy  output  1  high while in RUN

Behaviour:
- Reset: rst has priority over everything, sampled at clk edge. State=IDLE, ch=0, row=0, data_out_ready=0, busy=0, every img_out word=0.
- Counters: ch in 0..C-1, row in 0..IMG_OUT_SIZE-1. Width is $clog2 of the range, minimum 1.
- Pooling rule: out(ch,r,c) = OR of in(ch,2r,2c), in(ch,2r,2c+1), in(ch,2r+1,2c), in(ch,2r+1,2c+1).
- Odd IMG_IN_SIZE: the last input row and column are ignored.
- IDLE:
  - busy=0, data_out_ready=0.
  - If data_in_ready=1 at an edge: go to RUN with ch=0, row=0. img_out is not modified.
  - If data_in_ready=0: hold IDLE and clear img_out to 0 (matches the upstream clear-on-low convention).
- RUN:
  - busy=1.
  - Each edge writes the IMG_OUT_SIZE bits of output row `row` of channel `ch` into img_out[ch]. Other bits are unchanged.
  - Then row increments. On wrap, row=0 and ch increments.
  - On the edge that writes (C-1, IMG_OUT_SIZE-1): data_out_ready<=1 and state goes to DONE.
- DONE:
  - data_out_ready=1, busy=0, img_out held.
  - Stays in DONE until data_in_ready=0, then goes to IDLE on that edge. The same edge clears data_out_ready and img_out.
- Latency: the edge that first samples data_in_ready=1 is edge 0. data_out_ready is visible after edge C*IMG_OUT_SIZE (112 for the defaults). Total edges from request to done = C*IMG_OUT_SIZE+1.
- Abort: data_in_ready dropping during RUN goes to IDLE on the next edge. Counters zero, img_out cleared, data_out_ready stays 0. No partial result is ever flagged valid.
- Re-arm: a new frame needs data_in_ready low for at least one edge. A level held high after DONE does not restart the block.
- Simultaneous rst and data_in_ready: rst wins.
- Stability: img_in must not change while busy=1. Behaviour if it does is undefined, but only the rows written after the change are affected.

Optional Feature:
- Macro: BNN_POOL_MAJORITY_EN
- Defined: the pooling rule is a majority vote. Output=1 iff at least 2 of the 4 window bits are 1, computed as a 3-bit popcount compared with 2.
- Undefined: OR (max) pooling as above.
- Timing, handshake and counters are identical in both builds.

Test Plan:
- Reset mid-RUN: assert rst at edge 50 -> next cycle data_out_ready=0, busy=0, all img_out=0. A fresh frame then completes in 113 edges.
- All-ones input, defaults: data_in_ready high -> data_out_ready rises exactly 112 edges after the first sampled edge, every img_out word all ones. All-zeros input -> all zeros.
- Single pixel: in(ch3, r=5, c=9)=1, all other bits 0 -> only img_out[3] bit 2*14+4=32 set (OR build). With BNN_POOL_MAJORITY_EN -> all outputs 0. Setting in(3,4,8)=1 as well gives bit 32=1 in the majority build.
- Abort: drop data_in_ready at edge 30 -> no data_out_ready pulse. Re-raise after one low edge -> full 112-edge completion with correct data.
- Hold after DONE: keep data_in_ready high 20 extra cycles -> data_out_ready stays 1, img_out stable, busy 0. Drop it -> next cycle data_out_ready=0 and img_out=0.
- Odd size IMG_IN_SIZE=5, C=2 -> IMG_OUT_SIZE=2, done after 4 write edges. A pixel set only in row 4 or column 4 never appears in the output.
